// File: rtl/rob_tagged_if.sv
// Bus bundle for the tagged reorder buffer: dispatch, the two writeback
// channels, the commit/flush broadcast, the global enable and occupancy.
// The ROB itself connects through the slave modport; the surrounding
// pipeline (or a testbench) drives through the master modport.
interface rob_tagged_if #(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int RD_W   = 5
);
  logic              rdy;

  logic              dispatch_valid;
  logic [PC_W-1:0]   dispatch_pc;
  logic [RD_W-1:0]   dispatch_rd;
  logic [TAG_W-1:0]  dispatch_tag;
  logic              dispatch_ready;

  logic              alu_wb_valid;
  logic [TAG_W-1:0]  alu_wb_tag;
  logic [DATA_W-1:0] alu_wb_data;
  logic [PC_W-1:0]   alu_wb_jpc;

  logic              slb_wb_valid;
  logic [TAG_W-1:0]  slb_wb_tag;
  logic [DATA_W-1:0] slb_wb_data;

  logic              commit_valid;
  logic [RD_W-1:0]   commit_rd;
  logic [PC_W-1:0]   commit_pc;
  logic [DATA_W-1:0] commit_data;
  logic [TAG_W-1:0]  commit_tag;

  logic              flush;
  logic [PC_W-1:0]   redirect_pc;
  logic [TAG_W:0]    count;

  // Pipeline side: issues dispatches and writebacks, consumes commits.
  modport master (
    output rdy,
    output dispatch_valid, dispatch_pc, dispatch_rd,
    input  dispatch_tag, dispatch_ready,
    output alu_wb_valid, alu_wb_tag, alu_wb_data, alu_wb_jpc,
    output slb_wb_valid, slb_wb_tag, slb_wb_data,
    input  commit_valid, commit_rd, commit_pc, commit_data, commit_tag,
    input  flush, redirect_pc, count
  );

  // ROB side: accepts dispatches and writebacks, produces commits.
  modport slave (
    input  rdy,
    input  dispatch_valid, dispatch_pc, dispatch_rd,
    output dispatch_tag, dispatch_ready,
    input  alu_wb_valid, alu_wb_tag, alu_wb_data, alu_wb_jpc,
    input  slb_wb_valid, slb_wb_tag, slb_wb_data,
    output commit_valid, commit_rd, commit_pc, commit_data, commit_tag,
    output flush, redirect_pc, count
  );
endinterface

// File: rtl/rob_tagged.sv
// Tagged reorder buffer. Dispatch allocates the tail entry and hands its
// index out as the tag; ALU and SLB write results back by tag; the head
// entry retires in order once done. A committed entry whose resolved next
// PC differs from pc+4 raises a one-cycle flush carrying the redirect PC
// and empties the buffer on the same edge.
module rob_tagged #(
  parameter int DEPTH        = 16,
  parameter int TAG_W        = 4,
  parameter int DATA_W       = 32,
  parameter int PC_W         = 32,
  parameter int RD_W         = 5,
  parameter int READY_MARGIN = 3
) (
  input logic         clk,
  input logic         rst,
  rob_tagged_if.slave bus
);

  localparam logic [TAG_W:0]  DEPTH_C  = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0]  MARGIN_C = (TAG_W+1)'(READY_MARGIN);
  localparam logic [PC_W-1:0] PC_STEP  = PC_W'(4);

  // Per-entry control bits (reset) and payload (no reset needed, gated by valid).
  logic              valid_q [DEPTH];
  logic              valid_d [DEPTH];
  logic              done_q  [DEPTH];
  logic              done_d  [DEPTH];
  logic [PC_W-1:0]   pc_q    [DEPTH];
  logic [PC_W-1:0]   pc_d    [DEPTH];
  logic [RD_W-1:0]   rd_q    [DEPTH];
  logic [RD_W-1:0]   rd_d    [DEPTH];
  logic [PC_W-1:0]   jpc_q   [DEPTH];
  logic [PC_W-1:0]   jpc_d   [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [DATA_W-1:0] data_d  [DEPTH];

  logic [TAG_W-1:0]  head_q, head_d;
  logic [TAG_W-1:0]  tail_q, tail_d;
  logic [TAG_W:0]    count_q, count_d;

  logic              commit_valid_q, commit_valid_d;
  logic [RD_W-1:0]   commit_rd_q, commit_rd_d;
  logic [PC_W-1:0]   commit_pc_q, commit_pc_d;
  logic [DATA_W-1:0] commit_data_q, commit_data_d;
  logic [TAG_W-1:0]  commit_tag_q, commit_tag_d;
  logic              flush_q, flush_d;
  logic [PC_W-1:0]   redirect_pc_q, redirect_pc_d;

  logic              commit_fire;
  logic              mispredict;
  logic              dispatch_fire;
  logic              wb_enable;
  logic              alu_hit;
  logic              slb_hit;
  logic [TAG_W:0]    free_entries;

  // Head retires when it is both allocated and completed; nothing retires
  // during the flush cycle since the buffer was just emptied.
  assign commit_fire = valid_q[head_q] && done_q[head_q] && !flush_q;

  // Control-flow mismatch is judged on the entry leaving the buffer.
  assign mispredict = commit_fire && (jpc_q[head_q] != (pc_q[head_q] + PC_STEP));

  // A full buffer silently drops the dispatch; flush cycles drop it too.
  assign dispatch_fire = bus.dispatch_valid && (count_q < DEPTH_C) && !flush_q;

  // Writebacks are meaningless while the buffer is being discarded.
  assign wb_enable = !flush_q && !mispredict;

  // Stale or duplicate writebacks miss on valid/done; ALU wins a tag collision.
  assign alu_hit = bus.alu_wb_valid && wb_enable &&
                   valid_q[bus.alu_wb_tag] && !done_q[bus.alu_wb_tag];
  assign slb_hit = bus.slb_wb_valid && wb_enable &&
                   valid_q[bus.slb_wb_tag] && !done_q[bus.slb_wb_tag] &&
                   !(alu_hit && (bus.alu_wb_tag == bus.slb_wb_tag));

  assign free_entries = DEPTH_C - count_q;

  assign bus.dispatch_tag   = tail_q;
  assign bus.dispatch_ready = free_entries > MARGIN_C;
  assign bus.commit_valid   = commit_valid_q;
  assign bus.commit_rd      = commit_rd_q;
  assign bus.commit_pc      = commit_pc_q;
  assign bus.commit_data    = commit_data_q;
  assign bus.commit_tag     = commit_tag_q;
  assign bus.flush          = flush_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.count          = count_q;

  // Next-state for entries, pointers, occupancy and the commit/flush outputs.
  always_comb begin
    valid_d        = valid_q;
    done_d         = done_q;
    pc_d           = pc_q;
    rd_d           = rd_q;
    jpc_d          = jpc_q;
    data_d         = data_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    commit_valid_d = commit_valid_q;
    commit_rd_d    = commit_rd_q;
    commit_pc_d    = commit_pc_q;
    commit_data_d  = commit_data_q;
    commit_tag_d   = commit_tag_q;
    flush_d        = flush_q;
    redirect_pc_d  = redirect_pc_q;

    if (!bus.rdy) begin
      commit_valid_d = 1'b0;
      flush_d        = 1'b0;
    end else begin
      commit_valid_d = 1'b0;
      commit_pc_d    = '0;
      flush_d        = 1'b0;

      if (alu_hit) begin
        done_d[bus.alu_wb_tag] = 1'b1;
        data_d[bus.alu_wb_tag] = bus.alu_wb_data;
        jpc_d[bus.alu_wb_tag]  = bus.alu_wb_jpc;
      end

      if (slb_hit) begin
        done_d[bus.slb_wb_tag] = 1'b1;
        data_d[bus.slb_wb_tag] = bus.slb_wb_data;
      end

      if (dispatch_fire && !mispredict) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = 1'b0;
        pc_d[tail_q]    = bus.dispatch_pc;
        rd_d[tail_q]    = bus.dispatch_rd;
        jpc_d[tail_q]   = bus.dispatch_pc + PC_STEP;
        tail_d          = tail_q + 1'b1;
      end

      if (commit_fire) begin
        commit_valid_d  = 1'b1;
        commit_rd_d     = rd_q[head_q];
        commit_pc_d     = pc_q[head_q];
        commit_data_d   = data_q[head_q];
        commit_tag_d    = head_q;
        valid_d[head_q] = 1'b0;
        head_d          = head_q + 1'b1;
      end

      count_d = count_q + (TAG_W+1)'(dispatch_fire && !mispredict)
                        - (TAG_W+1)'(commit_fire);

      if (mispredict) begin
        flush_d       = 1'b1;
        redirect_pc_d = jpc_q[head_q];
        head_d        = '0;
        tail_d        = '0;
        count_d       = '0;
        for (int i = 0; i < DEPTH; i++) begin
          valid_d[i] = 1'b0;
        end
      end
    end
  end

  // Control state with synchronous reset; reset discards every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        done_q[i]  <= 1'b0;
      end
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_rd_q    <= '0;
      commit_pc_q    <= '0;
      commit_data_q  <= '0;
      commit_tag_q   <= '0;
      flush_q        <= 1'b0;
      redirect_pc_q  <= '0;
    end else begin
      valid_q        <= valid_d;
      done_q         <= done_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_rd_q    <= commit_rd_d;
      commit_pc_q    <= commit_pc_d;
      commit_data_q  <= commit_data_d;
      commit_tag_q   <= commit_tag_d;
      flush_q        <= flush_d;
      redirect_pc_q  <= redirect_pc_d;
    end
  end

  // Entry payload; only meaningful while the matching valid bit is set.
  always_ff @(posedge clk) begin
    pc_q   <= pc_d;
    rd_q   <= rd_d;
    jpc_q  <= jpc_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_rob_tagged.sv
// Directed testbench for rob_tagged: in-order retirement, out-of-order
// writeback, full/ready thresholds, mispredict flush, channel collisions,
// stale writebacks and global stall.
module tb_rob_tagged;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rob_tagged_if bus ();

  rob_tagged dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle of inputs, advance past the edge, then return inputs to idle.
  task automatic applyStimulus(
    input logic        dv,
    input logic [31:0] dpc,
    input logic [4:0]  drd,
    input logic        av,
    input logic [3:0]  at,
    input logic [31:0] ad,
    input logic [31:0] aj,
    input logic        sv,
    input logic [3:0]  st,
    input logic [31:0] sd
  );
    bus.dispatch_valid = dv;
    bus.dispatch_pc    = dpc;
    bus.dispatch_rd    = drd;
    bus.alu_wb_valid   = av;
    bus.alu_wb_tag     = at;
    bus.alu_wb_data    = ad;
    bus.alu_wb_jpc     = aj;
    bus.slb_wb_valid   = sv;
    bus.slb_wb_tag     = st;
    bus.slb_wb_data    = sd;
    @(posedge clk);
    #1;
    bus.dispatch_valid = 1'b0;
    bus.alu_wb_valid   = 1'b0;
    bus.slb_wb_valid   = 1'b0;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 32'h0, 5'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic dispatchOp(input logic [31:0] pc, input logic [4:0] rd);
    applyStimulus(1'b1, pc, rd, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic aluWb(input logic [3:0] tag, input logic [31:0] data, input logic [31:0] jpc);
    applyStimulus(1'b0, 32'h0, 5'h0, 1'b1, tag, data, jpc, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic slbWb(input logic [3:0] tag, input logic [31:0] data);
    applyStimulus(1'b0, 32'h0, 5'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, tag, data);
  endtask

  task automatic doReset();
    rst = 1'b1;
    idleCycle();
    rst = 1'b0;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", name, observed, expected);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    bus.rdy            = 1'b1;
    bus.dispatch_valid = 1'b0;
    bus.dispatch_pc    = '0;
    bus.dispatch_rd    = '0;
    bus.alu_wb_valid   = 1'b0;
    bus.alu_wb_tag     = '0;
    bus.alu_wb_data    = '0;
    bus.alu_wb_jpc     = '0;
    bus.slb_wb_valid   = 1'b0;
    bus.slb_wb_tag     = '0;
    bus.slb_wb_data    = '0;
    idleCycle();
    idleCycle();
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_commit_valid", 64'(bus.commit_valid), 64'd0);
    checkOutput("rst_commit_pc", 64'(bus.commit_pc), 64'd0);
    checkOutput("rst_commit_rd", 64'(bus.commit_rd), 64'd0);
    checkOutput("rst_commit_data", 64'(bus.commit_data), 64'd0);
    checkOutput("rst_commit_tag", 64'(bus.commit_tag), 64'd0);
    checkOutput("rst_flush", 64'(bus.flush), 64'd0);
    checkOutput("rst_redirect_pc", 64'(bus.redirect_pc), 64'd0);
    checkOutput("rst_count", 64'(bus.count), 64'd0);
    checkOutput("rst_dispatch_tag", 64'(bus.dispatch_tag), 64'd0);
    checkOutput("rst_dispatch_ready", 64'(bus.dispatch_ready), 64'd1);

    $display("[TB] single dispatch / writeback / commit");
    dispatchOp(32'h100, 5'd3);
    checkOutput("t1_count_after_dispatch", 64'(bus.count), 64'd1);
    checkOutput("t1_next_tag", 64'(bus.dispatch_tag), 64'd1);
    aluWb(4'd0, 32'd7, 32'h104);
    checkOutput("t1_no_commit_yet", 64'(bus.commit_valid), 64'd0);
    idleCycle();
    checkOutput("t1_commit_valid", 64'(bus.commit_valid), 64'd1);
    checkOutput("t1_commit_pc", 64'(bus.commit_pc), 64'h100);
    checkOutput("t1_commit_rd", 64'(bus.commit_rd), 64'd3);
    checkOutput("t1_commit_data", 64'(bus.commit_data), 64'd7);
    checkOutput("t1_commit_tag", 64'(bus.commit_tag), 64'd0);
    checkOutput("t1_flush", 64'(bus.flush), 64'd0);
    checkOutput("t1_count", 64'(bus.count), 64'd0);
    idleCycle();
    checkOutput("t1_pulse_ends", 64'(bus.commit_valid), 64'd0);
    checkOutput("t1_pc_cleared", 64'(bus.commit_pc), 64'd0);

    $display("[TB] out-of-order writeback, in-order commit");
    doReset();
    dispatchOp(32'h0, 5'd1);
    dispatchOp(32'h4, 5'd2);
    dispatchOp(32'h8, 5'd4);
    checkOutput("t2_count3", 64'(bus.count), 64'd3);
    aluWb(4'd2, 32'hA2, 32'hC);
    checkOutput("t2_tag2_no_commit", 64'(bus.commit_valid), 64'd0);
    aluWb(4'd1, 32'hA1, 32'h8);
    checkOutput("t2_tag1_no_commit", 64'(bus.commit_valid), 64'd0);
    aluWb(4'd0, 32'hA0, 32'h4);
    checkOutput("t2_tag0_no_commit", 64'(bus.commit_valid), 64'd0);
    idleCycle();
    checkOutput("t2_c0_valid", 64'(bus.commit_valid), 64'd1);
    checkOutput("t2_c0_pc", 64'(bus.commit_pc), 64'h0);
    checkOutput("t2_c0_data", 64'(bus.commit_data), 64'hA0);
    idleCycle();
    checkOutput("t2_c1_valid", 64'(bus.commit_valid), 64'd1);
    checkOutput("t2_c1_pc", 64'(bus.commit_pc), 64'h4);
    checkOutput("t2_c1_rd", 64'(bus.commit_rd), 64'd2);
    idleCycle();
    checkOutput("t2_c2_valid", 64'(bus.commit_valid), 64'd1);
    checkOutput("t2_c2_pc", 64'(bus.commit_pc), 64'h8);
    checkOutput("t2_c2_tag", 64'(bus.commit_tag), 64'd2);
    checkOutput("t2_count0", 64'(bus.count), 64'd0);

    $display("[TB] fill to capacity");
    doReset();
    for (int i = 0; i < 16; i++) begin
      dispatchOp(32'h200 + 32'(4 * i), 5'(i));
      if (i == 11) checkOutput("t3_ready_at12", 64'(bus.dispatch_ready), 64'd1);
      if (i == 12) checkOutput("t3_ready_at13", 64'(bus.dispatch_ready), 64'd0);
    end
    checkOutput("t3_count16", 64'(bus.count), 64'd16);
    checkOutput("t3_ready_full", 64'(bus.dispatch_ready), 64'd0);
    checkOutput("t3_tail_wrapped", 64'(bus.dispatch_tag), 64'd0);
    dispatchOp(32'h999, 5'd31);
    checkOutput("t3_overflow_ignored", 64'(bus.count), 64'd16);
    slbWb(4'd0, 32'h55);
    checkOutput("t3_count_before_commit", 64'(bus.count), 64'd16);
    idleCycle();
    checkOutput("t3_commit_valid", 64'(bus.commit_valid), 64'd1);
    checkOutput("t3_commit_pc", 64'(bus.commit_pc), 64'h200);
    checkOutput("t3_commit_data", 64'(bus.commit_data), 64'h55);
    checkOutput("t3_count15", 64'(bus.count), 64'd15);
    checkOutput("t3_tag_before_refill", 64'(bus.dispatch_tag), 64'd0);
    dispatchOp(32'h300, 5'd7);
    checkOutput("t3_count_refill", 64'(bus.count), 64'd16);
    checkOutput("t3_tag_after_refill", 64'(bus.dispatch_tag), 64'd1);
    slbWb(4'd1, 32'h66);
    idleCycle();
    checkOutput("t3_second_commit_pc", 64'(bus.commit_pc), 64'h204);
    checkOutput("t3_second_commit_tag", 64'(bus.commit_tag), 64'd1);
    checkOutput("t3_second_commit_rd", 64'(bus.commit_rd), 64'd1);

    $display("[TB] mispredict flush");
    doReset();
    dispatchOp(32'h20, 5'd1);
    dispatchOp(32'h24, 5'd2);
    dispatchOp(32'h28, 5'd3);
    aluWb(4'd0, 32'h1, 32'h80);
    dispatchOp(32'h30, 5'd4);
    checkOutput("t4_commit_valid", 64'(bus.commit_valid), 64'd1);
    checkOutput("t4_commit_pc", 64'(bus.commit_pc), 64'h20);
    checkOutput("t4_flush", 64'(bus.flush), 64'd1);
    checkOutput("t4_redirect", 64'(bus.redirect_pc), 64'h80);
    checkOutput("t4_count_cleared", 64'(bus.count), 64'd0);
    checkOutput("t4_tail_cleared", 64'(bus.dispatch_tag), 64'd0);
    applyStimulus(1'b1, 32'h40, 5'd5, 1'b1, 4'd1, 32'h2, 32'h28, 1'b0, 4'h0, 32'h0);
    checkOutput("t4_flush_self_clears", 64'(bus.flush), 64'd0);
    checkOutput("t4_flush_dispatch_dropped", 64'(bus.count), 64'd0);
    checkOutput("t4_no_commit", 64'(bus.commit_valid), 64'd0);
    dispatchOp(32'h50, 5'd6);
    checkOutput("t4_post_flush_count", 64'(bus.count), 64'd1);
    aluWb(4'd0, 32'hC, 32'h54);
    idleCycle();
    checkOutput("t4_post_flush_commit_pc", 64'(bus.commit_pc), 64'h50);
    checkOutput("t4_post_flush_commit_data", 64'(bus.commit_data), 64'hC);
    checkOutput("t4_post_flush_no_flush", 64'(bus.flush), 64'd0);

    $display("[TB] writeback collisions and stale writeback");
    doReset();
    dispatchOp(32'h60, 5'd8);
    applyStimulus(1'b0, 32'h0, 5'h0, 1'b1, 4'd0, 32'd5, 32'h64, 1'b1, 4'd0, 32'd9);
    idleCycle();
    checkOutput("t5_alu_wins", 64'(bus.commit_data), 64'd5);
    checkOutput("t5_collide_count", 64'(bus.count), 64'd0);
    slbWb(4'd0, 32'hAA);
    checkOutput("t5_stale_count", 64'(bus.count), 64'd0);
    checkOutput("t5_stale_no_commit", 64'(bus.commit_valid), 64'd0);
    checkOutput("t5_tail", 64'(bus.dispatch_tag), 64'd1);
    dispatchOp(32'h70, 5'd9);
    dispatchOp(32'h74, 5'd10);
    applyStimulus(1'b0, 32'h0, 5'h0, 1'b1, 4'd1, 32'h11, 32'h74, 1'b1, 4'd2, 32'h22);
    idleCycle();
    checkOutput("t5_dual_c1_tag", 64'(bus.commit_tag), 64'd1);
    checkOutput("t5_dual_c1_data", 64'(bus.commit_data), 64'h11);
    idleCycle();
    checkOutput("t5_dual_c2_valid", 64'(bus.commit_valid), 64'd1);
    checkOutput("t5_dual_c2_pc", 64'(bus.commit_pc), 64'h74);
    checkOutput("t5_dual_c2_data", 64'(bus.commit_data), 64'h22);
    checkOutput("t5_dual_count", 64'(bus.count), 64'd0);

    $display("[TB] global stall");
    doReset();
    dispatchOp(32'h90, 5'd9);
    aluWb(4'd0, 32'd3, 32'h94);
    bus.rdy = 1'b0;
    idleCycle();
    checkOutput("t6_stall1_valid", 64'(bus.commit_valid), 64'd0);
    checkOutput("t6_stall1_count", 64'(bus.count), 64'd1);
    dispatchOp(32'hA0, 5'd1);
    checkOutput("t6_stall2_valid", 64'(bus.commit_valid), 64'd0);
    checkOutput("t6_stall2_count", 64'(bus.count), 64'd1);
    checkOutput("t6_stall2_tag", 64'(bus.dispatch_tag), 64'd1);
    idleCycle();
    checkOutput("t6_stall3_valid", 64'(bus.commit_valid), 64'd0);
    bus.rdy = 1'b1;
    idleCycle();
    checkOutput("t6_resume_valid", 64'(bus.commit_valid), 64'd1);
    checkOutput("t6_resume_pc", 64'(bus.commit_pc), 64'h90);
    checkOutput("t6_resume_rd", 64'(bus.commit_rd), 64'd9);
    checkOutput("t6_resume_count", 64'(bus.count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
